// File: rtl/gray_stream_converter.sv
// Two-stage valid/ready pipeline that converts each beat binary->Gray or Gray->binary by its mode bit.
// Optional Gray step-violation checking is enabled by defining GRAY_STEP_CHECK_EN.
module gray_stream_converter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_mode,
  output logic         step_err
);

  function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
    logic [N-1:0] g;
    g[N-1] = b[N-1];
    for (int i = 0; i < int'(N) - 1; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  // Serial XOR chain from the MSB down; settles within one cycle.
  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = int'(N) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic         a_valid_q, a_valid_d;
  logic [N-1:0] a_data_q,  a_data_d;
  logic         a_mode_q,  a_mode_d;
  logic         a_err_q,   a_err_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q,  out_data_d;
  logic         out_mode_q,  out_mode_d;
  logic         step_err_q,  step_err_d;

  logic b_load_c;
  logic in_ready_c;
  logic accept_c;
  logic in_err_c;

  assign b_load_c   = ~out_valid_q | out_ready;
  assign in_ready_c = rst_n & (~a_valid_q | b_load_c);
  assign accept_c   = in_valid & in_ready_c;

`ifdef GRAY_STEP_CHECK_EN
  logic [N-1:0] prev_q;
  logic         prev_vld_q;

  // Flag Gray beats that do not move exactly one bit from the previous Gray beat.
  assign in_err_c = in_mode & prev_vld_q & ~$onehot(in_data ^ prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (accept_c && in_mode) begin
      prev_q     <= in_data;
      prev_vld_q <= 1'b1;
    end
  end
`else
  assign in_err_c = 1'b0;
`endif

  always_comb begin
    a_valid_d   = a_valid_q;
    a_data_d    = a_data_q;
    a_mode_d    = a_mode_q;
    a_err_d     = a_err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    step_err_d  = step_err_q;

    if (b_load_c) begin
      out_valid_d = a_valid_q;
      if (a_valid_q) begin
        out_data_d = a_mode_q ? gray2bin(a_data_q) : bin2gray(a_data_q);
        out_mode_d = a_mode_q;
        step_err_d = a_err_q;
      end
    end

    if (accept_c) begin
      a_valid_d = 1'b1;
      a_data_d  = in_data;
      a_mode_d  = in_mode;
      a_err_d   = in_err_c;
    end else if (b_load_c) begin
      a_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q   <= 1'b0;
      a_data_q    <= '0;
      a_mode_q    <= 1'b0;
      a_err_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_data_q    <= a_data_d;
      a_mode_q    <= a_mode_d;
      a_err_q     <= a_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      step_err_q  <= step_err_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;
  assign step_err  = step_err_q;

endmodule
